// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative radix-2 multiply/divide engine with HI/LO result registers.
//   An op issued with start in IDLE runs WIDTH shift-add / restoring
//   shift-subtract steps on operand magnitudes, then a sign-fixup cycle
//   that writes HI/LO and pulses done.
//
// Ports
//   CLK      in   1      clock, rising edge
//   nRST     in   1      asynchronous active-low reset
//   start    in   1      issue op (sampled only in IDLE, ignored with abort)
//   op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   portA    in   WIDTH  multiplicand / dividend
//   portB    in   WIDTH  multiplier / divisor
//   abort    in   1      kill the in-flight op; HI/LO untouched
//   hi_we    in   1      MTHI write enable (IDLE only)
//   lo_we    in   1      MTLO write enable (IDLE only)
//   wdata    in   WIDTH  MTHI/MTLO data
//   busy     out  1      op in flight
//   done     out  1      one-cycle pulse after HI/LO update
//   divzero  out  1      last op divided by zero (valid with done)
//   hi, lo   out  WIDTH  HI / LO registers
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN
  } state_t;

  state_t           state_q,    state_d;
  logic             is_div_q,   is_div_d;
  logic [WIDTH-1:0] opb_q,      opb_d;      // multiplicand (mul) / divisor (div)
  logic [WIDTH-1:0] q_q,        q_d;        // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] acc_q,      acc_d;      // product high / partial remainder
  logic [WIDTH-1:0] a_raw_q,    a_raw_d;    // original dividend for divide-by-zero
  logic             neg_res_q,  neg_res_d;  // product / quotient must be negated
  logic             neg_rem_q,  neg_rem_d;  // remainder must be negated
  logic             dz_q,       dz_d;
  logic [CW-1:0]    counter_q,  counter_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic [WIDTH-1:0] lo_q,       lo_d;
  logic             done_q,     done_d;
  logic             divzero_q,  divzero_d;

  // Operand conditioning at issue
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Datapath step / fixup terms
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg = ~op[0] & portA[WIDTH-1];
  assign b_neg = ~op[0] & portB[WIDTH-1];
  assign mag_a = a_neg ? -portA : portA;
  assign mag_b = b_neg ? -portB : portB;

  // Multiply: add multiplicand when the current multiplier bit is set,
  // then shift {sum, multiplier} right one place.
  assign mul_sum = {1'b0, acc_q} + ({1'b0, opb_q} & {(WIDTH+1){q_q[0]}});

  // Divide: shift next dividend bit into the remainder and subtract when it fits.
  // The remainder stays below the divisor, so the difference fits WIDTH bits.
  assign div_trial = {acc_q, q_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, opb_q});
  assign div_diff  = div_trial[WIDTH-1:0] - opb_q;

  assign prod     = {acc_q, q_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -q_q : q_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    opb_d     = opb_q;
    q_d       = q_q;
    acc_d     = acc_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    counter_d = counter_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !abort) begin
          state_d   = S_RUN;
          is_div_d  = op[1];
          opb_d     = op[1] ? mag_b : mag_a;
          q_d       = op[1] ? mag_a : mag_b;
          acc_d     = '0;
          a_raw_d   = portA;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[1] & (portB == '0);
          counter_d = '0;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge ? div_diff : div_trial[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
          end
          counter_d = counter_q + CW'(1);
          if (counter_q == CW'(WIDTH - 1)) state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        state_d = S_IDLE;
        if (!abort) begin
          if (is_div_q) begin
            if (dz_q) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d    = 1'b1;
          divzero_d = dz_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      opb_q     <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      counter_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      opb_q     <= opb_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      counter_q <= counter_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed and random ops checked through an
// expected-result queue drained by an independent done monitor.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  portA, portB;
  logic          abort;
  logic          hi_we, lo_we;
  logic [W-1:0]  wdata;
  logic          busy, done, divzero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op),
    .portA(portA), .portB(portB), .abort(abort),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .divzero(divzero),
    .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    e.dz = 1'b0;
    case (o)
      2'b00: begin
        sp = sa * sb;
        e.hi = sp[63:32]; e.lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32]; e.lo = up[31:0];
      end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          e.hi = sr[31:0]; e.lo = sq[31:0];
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (nRST && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got done=1 expected no done (hi=%h lo=%h)", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
        chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
        chk("result_divzero", {63'd0, divzero}, {63'd0, e.dz});
      end
    end
  end

  // Issue one op, poke it with ignored start pulses and a busy-time MTHI,
  // and check latency, busy and the single-cycle done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] hi_before;
    @(negedge CLK);
    start = 1'b1; op = o; portA = a; portB = b;
    exp_q.push_back(model(o, a, b));
    @(posedge CLK);
    #1 start = 1'b0; op = 2'($urandom); portA = $urandom; portB = $urandom;
    @(negedge CLK);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    hi_before = hi;
    n = 0;
    while (n < 100) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (done) break;
      hi_we = 1'b0;
      if (n == 3) begin
        chk("mthi_busy_ignored", {32'd0, hi}, {32'd0, hi_before});
      end
      if (n == 2) begin
        hi_we = 1'b1; wdata = $urandom;
      end
      if (n < int'(W) - 1 && $urandom_range(0, 3) == 0) begin
        start = 1'b1; portA = $urandom; portB = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done after %0d cycles expected %0d", n, W + 1);
    end else begin
      chk("latency", 64'(n), 64'(W + 1));
      chk("busy_at_done", {63'd0, busy}, 64'd0);
    end
    @(negedge CLK);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic write_hilo(input logic [W-1:0] v);
    @(negedge CLK);
    hi_we = 1'b1; lo_we = 1'b1; wdata = v;
    @(negedge CLK);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi", {32'd0, hi}, {32'd0, v});
    chk("mtlo", {32'd0, lo}, {32'd0, v});
  endtask

  // Start an op, then abort it after `k` edges; no done and HI/LO untouched.
  task automatic abort_after(input int k);
    @(negedge CLK);
    start = 1'b1; op = 2'b01; portA = 32'hDEAD_BEEF; portB = 32'h1234_5678;
    @(negedge CLK);
    start = 1'b0;
    repeat (k - 1) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_busy_drop", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge CLK);
    chk("abort_hi_kept", {32'd0, hi}, 64'h1234);
    chk("abort_lo_kept", {32'd0, lo}, 64'h1234);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    nRST = 1'b0; start = 1'b0; op = 2'b00; portA = '0; portB = '0;
    abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_divzero", {63'd0, divzero}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Directed corner cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd5, 32'd0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);

    // Abort mid-RUN, abort in the SIGN cycle, abort together with start in IDLE
    write_hilo(32'h1234);
    abort_after(10);
    abort_after(W + 1);
    @(negedge CLK);
    start = 1'b1; abort = 1'b1; op = 2'b00; portA = 32'd3; portB = 32'd3;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    chk("abort_blocks_start", {63'd0, busy}, 64'd0);

    // MTHI/MTLO in the same IDLE cycle as start: write lands, result overwrites
    @(negedge CLK);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
    start = 1'b1; op = 2'b11; portA = 32'd1000; portB = 32'd33;
    exp_q.push_back(model(2'b11, 32'd1000, 32'd33));
    @(negedge CLK);
    hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    chk("start_mthi_hi", {32'd0, hi}, 64'hA5A5_0F0F);
    chk("start_mtlo_lo", {32'd0, lo}, 64'hA5A5_0F0F);
    repeat (40) @(negedge CLK);

    // Random ops against the reference
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick());
    end

    // Asynchronous reset mid-RUN clears state without a clock edge
    @(negedge CLK);
    start = 1'b1; op = 2'b00; portA = 32'h0BAD_F00D; portB = 32'h7;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_hi", {32'd0, hi}, 64'd0);
    chk("async_rst_lo", {32'd0, lo}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    chk("no_done_after_reset", {63'd0, busy}, 64'd0);

    // MTHI alone in IDLE
    @(negedge CLK);
    hi_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge CLK);
    hi_we = 1'b0;
    chk("mthi_idle", {32'd0, hi}, 64'hCAFE_0001);
    chk("mthi_lo_untouched", {32'd0, lo}, 64'd0);

    repeat (3) @(negedge CLK);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
